// File: rtl/prog_loader.sv
// prog_loader: frames a byte stream into 18-bit words and writes the RAT program memory,
// holding the MCU in reset until a load completes with a good checksum.
module prog_loader #(
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
   parameter logic [7:0]  HDR_BYTE       = 8'hA5
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        start_i,
   input  logic [7:0]  rx_data_i,
   input  logic        rx_valid_i,
   output logic        we_o,
   output logic [9:0]  waddr_o,
   output logic [17:0] wdata_o,
   output logic        mcu_hold_o,
   output logic        done_o,
   output logic        err_o
);
   typedef enum logic [3:0] {IDLE, WAIT_HDR, CNT_HI, CNT_LO, B0, B1, B2, CHK, DONE, ERR} state_t;
   localparam logic [26:0] TO_LAST = 27'(TIMEOUT_CYCLES - 1);
   state_t      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d, waddr_q, waddr_d;
   logic [7:0]  sum_q, sum_d, b1_q, b1_d;
   logic [1:0]  b0_q, b0_d;
   logic [17:0] wdata_q, wdata_d;
   logic [26:0] timer_q, timer_d;
   logic        we_q, we_d, hold_q, done_q, err_q;
   logic        timing, acc;
   always_comb begin
      timing  = state_q inside {CNT_HI, CNT_LO, B0, B1, B2, CHK};
      acc     = rx_valid_i && (timing || state_q == WAIT_HDR);
      state_d = state_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      b0_d    = b0_q;
      b1_d    = b1_q;
      wdata_d = wdata_q;
      we_d    = 1'b0;
      // the address advances after each write pulse but saturates at the last word
      waddr_d = (we_q && waddr_q != 10'h3FF) ? waddr_q + 10'd1 : waddr_q;
      timer_d = timing ? timer_q + 27'd1 : '0;
      if (start_i) begin
         state_d = WAIT_HDR;
         sum_d   = '0;
         timer_d = '0;
         waddr_d = '0;
      end else if (acc) begin
         timer_d = '0;
         sum_d   = (timing && state_q != CHK) ? sum_q + rx_data_i : sum_q;
         case (state_q)
            WAIT_HDR: state_d = (rx_data_i == HDR_BYTE) ? CNT_HI : WAIT_HDR;
            CNT_HI: begin
               cnt_d[9:8] = rx_data_i[1:0];
               state_d    = CNT_LO;
            end
            CNT_LO: begin
               cnt_d[7:0] = rx_data_i;
               state_d    = B0;
            end
            B0: begin
               b0_d    = rx_data_i[1:0];
               state_d = B1;
            end
            B1: begin
               b1_d    = rx_data_i;
               state_d = B2;
            end
            B2: begin
               we_d    = 1'b1;
               wdata_d = {b0_q, b1_q, rx_data_i};
               cnt_d   = cnt_q - 10'd1;
               state_d = (cnt_q == 10'd0) ? CHK : B0;
            end
            CHK:     state_d = (rx_data_i == sum_q) ? DONE : ERR;
            default: state_d = state_q;
         endcase
      end else if (timing && timer_q == TO_LAST) begin
         state_d = ERR;
      end
   end
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sum_q   <= '0;
         b0_q    <= '0;
         b1_q    <= '0;
         wdata_q <= '0;
         waddr_q <= '0;
         timer_q <= '0;
         we_q    <= 1'b0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         b0_q    <= b0_d;
         b1_q    <= b1_d;
         wdata_q <= wdata_d;
         waddr_q <= waddr_d;
         timer_q <= timer_d;
         we_q    <= we_d;
         hold_q  <= !(state_d inside {IDLE, DONE});
         done_q  <= state_d == DONE;
         err_q   <= state_d == ERR;
      end
   end
   assign we_o       = we_q;
   assign waddr_o    = waddr_q;
   assign wdata_o    = wdata_q;
   assign mcu_hold_o = hold_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
endmodule

// File: doc/prog_loader.md
# prog_loader

Sequences runtime reloading of the RAT MCU's 1024x18 program memory from a byte stream, such as the UART receiver. It frames and validates incoming bytes, assembles 18-bit instruction words and drives the program memory's write port. While a load is in progress it holds the MCU in reset, so the CPU never fetches a partially written program. It sits between the UART receiver and the program memory's write side, beside the MCU top level.

## Interface
- TIMEOUT_CYCLES, default 50_000_000: idle cycles allowed between bytes in a frame before abort (1 s at 50 MHz).
- HDR_BYTE, default 8'hA5: frame start marker.
- CLK  in  1  system clock; all logic on rising edge.
- RST_N  in  1  synchronous, active-low reset.
- START  in  1  one-cycle request to begin or restart a load.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  one-cycle strobe; RX_DATA valid this cycle.
- WE  out  1  program memory write enable, one-cycle pulse.
- WADDR  out  10  program memory write address.
- WDATA  out  18  program memory write data.
- MCU_HOLD  out  1  holds the MCU in reset while high.
- DONE  out  1  last load completed with a good checksum (level).
- ERR  out  1  last load aborted (level).

## Operation
- Frame format, after START:
  - HDR_BYTE.
  - CNT_HI: low 2 bits used, upper 6 ignored.
  - CNT_LO.
  - Word count = {CNT_HI[1:0], CNT_LO} + 1, giving 1..1024 words.
  - 3 bytes per word, big-endian: B0[1:0] = WDATA[17:16], B1 = WDATA[15:8], B2 = WDATA[7:0]. Upper 6 bits of B0 are ignored.
  - CHK byte: 8-bit modulo-256 sum of every byte after the header, including the count bytes. The header and CHK itself are excluded.
- States:
  - IDLE to WAIT_HDR on START.
  - WAIT_HDR to CNT_HI on byte == HDR_BYTE. Any other byte is discarded.
  - CNT_HI to CNT_LO to B0 on each accepted byte.
  - B0 to B1 to B2 on each accepted byte.
  - B2: on accept, perform the write, then go to B0 if words remain, else CHK.
  - CHK to DONE if the sum matches, else to ERR.
  - DONE/ERR to WAIT_HDR on START.
- Outputs by state:
  - MCU_HOLD = 1 in every state except IDLE and DONE.
  - ERR stays asserted in the ERR state, so MCU_HOLD stays high because the program is partial.
- Write address:
  - WADDR is cleared to 0 when START is accepted.
  - WADDR increments by 1 after each WE pulse.
  - A 1024-word load ends with WADDR = 1023. There is no further increment, so it never wraps to 0.
- Running sum:
  - 8-bit register, cleared on START, wraps modulo 256.
  - Updated on every accepted byte in CNT_HI, CNT_LO, B0, B1 and B2.
- Timeout:
  - 27-bit-capable counter, cleared on START and on every accepted byte.
  - Counts only in CNT_HI through CHK. WAIT_HDR waits indefinitely.
  - On reaching TIMEOUT_CYCLES, go to ERR.
- Simultaneous events:
  - START with RX_VALID in the same cycle: START wins and the byte is discarded.
  - START in any state, including mid-frame, restarts at WAIT_HDR. Sum, address and timer are cleared; DONE and ERR are cleared.
  - RX_VALID in IDLE, DONE or ERR is ignored.
- Reset (RST_N low at a clock edge), from any state including mid-load:
  - Next state is IDLE.
  - WE = 0, WADDR = 0, WDATA = 0.
  - MCU_HOLD = 0, DONE = 0, ERR = 0.
  - Sum = 0, timer = 0.

## Timing
- All outputs are registered.
- START sampled at edge k: MCU_HOLD = 1, DONE = 0 and ERR = 0 from edge k onward.
- B2 accepted at edge k:
  - WE = 1 for exactly the cycle after edge k.
  - WADDR and WDATA are stable during that cycle.
  - WADDR shows the incremented value from edge k+1.
- Minimum spacing between RX_VALID strobes is 1 cycle. Back-to-back bytes are accepted every cycle.
- CHK accepted at edge k: DONE = 1, or ERR = 1, from edge k. On DONE, MCU_HOLD = 0 from edge k.
- Timeout: ERR rises TIMEOUT_CYCLES cycles after the last accepted byte.

## Test plan
- Reset, then a 1-word load:
  - Stimulus: START; bytes A5 00 00 02 34 56 CHK=8C.
  - Response: one WE pulse with WADDR = 0, WDATA = 18'h23456. DONE = 1, MCU_HOLD = 0, ERR = 0.
- Full 1024-word load:
  - Stimulus: CNT = 03 FF, word i = i, back-to-back bytes, correct CHK.
  - Response: 1024 WE pulses at addresses 0..1023, each with WDATA = address. No wrap. DONE = 1.
- Bad checksum:
  - Stimulus: the 1-word frame with CHK = 8D.
  - Response: WE pulsed once, ERR = 1, MCU_HOLD stays 1, DONE = 0.
- Garbage before header:
  - Stimulus: bytes 00 FF A4, then a valid 1-word frame.
  - Response: the first three bytes cause no state change; the load completes with DONE = 1.
- Timeout and restart:
  - Stimulus: TIMEOUT_CYCLES = 100; stall 100 cycles after CNT_LO.
  - Response: ERR = 1. A following START clears ERR, and a valid frame then reaches DONE with writes starting at WADDR = 0.
- Reset mid-frame and START/RX_VALID collision:
  - Stimulus: RST_N = 0 after B1.
  - Response: all outputs 0 and no WE pulse.
  - Stimulus: START in the same cycle as an A5 byte.
  - Response: A5 is discarded and the block waits for the next header.
